// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and wrapped-increment helper for modulo counters
package counter_pkg;

  localparam int MOD13     = 13;
  localparam int CNT4_W    = 4;
  localparam int CNT_MAX_W = 16;

  // Any value at or beyond modulus-1 wraps to 0, so upset states self-clear in one edge.
  function automatic logic [CNT_MAX_W-1:0] next_mod(input logic [CNT_MAX_W-1:0] cur,
                                                     input logic [CNT_MAX_W:0]   modulus);
    logic [CNT_MAX_W:0] last;
    last = modulus - 1'b1;
    if ({1'b0, cur} >= last) begin
      next_mod = '0;
    end else begin
      next_mod = cur + 1'b1;
    end
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - generic free-running modulo-N up-counter, async active-low reset
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int MODULUS = MOD13,
  parameter int WIDTH   = CNT4_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [WIDTH-1:0] count_o
);

  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("mod_n_counter: WIDTH must be in 1..%0d", CNT_MAX_W);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = WIDTH'(next_mod(CNT_MAX_W'(count_q), (CNT_MAX_W + 1)'(MODULUS)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  // Every loaded value is legal, even when the current state was upset.
  a_next_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(count_d) < MODULUS);
  a_reset_zero: assert property (@(posedge clk_i) !rst_ni |-> count_q == '0);

endmodule

// File: rtl/mod13_counter.sv
// rtl/mod13_counter.sv - free-running modulus-13 counter, Q cycles 0..12
module mod13_counter
  import counter_pkg::*;
#(
  parameter int MODULUS = MOD13,
  parameter int WIDTH   = CNT4_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Q
);

  mod_n_counter #(
    .MODULUS(MODULUS),
    .WIDTH  (WIDTH)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .count_o(Q)
  );

endmodule

// File: tb/tb_mod13_counter.sv
// tb/tb_mod13_counter.sv - directed self-checking bench for mod13_counter
module tb_mod13_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Q;
  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q;

  mod13_counter dut (.clk(clk), .reset(reset), .Q(Q));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    total++;
    if (Q !== 4'd0) begin bad++; $display("FAIL reset_immediate: got %0d want 0", Q); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (Q !== 4'd0) begin bad++; $display("FAIL reset_hold[%0d]: got %0d want 0", i, Q); end
    end
  endtask

  task automatic test_count_13;
    logic [3:0] want [13];
    want = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0};
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      total++;
      if (Q !== want[i]) begin bad++; $display("FAIL count13[%0d]: got %0d want %0d", i, Q, want[i]); end
    end
    exp_q = 4'd0;
  endtask

  task automatic test_run_30;
    for (int i = 0; i < 30; i++) begin
      exp_q = (exp_q == 4'd12) ? 4'd0 : exp_q + 4'd1;
      tick();
      total++;
      if (Q !== exp_q || Q > 4'd12) begin
        bad++; $display("FAIL run30[%0d]: got %0d want %0d", i, Q, exp_q);
      end
    end
  endtask

  task automatic advance_to(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (exp_q != target && n < 13) begin
      exp_q = (exp_q == 4'd12) ? 4'd0 : exp_q + 4'd1;
      tick();
      n++;
    end
    total++;
    if (Q !== target) begin bad++; $display("FAIL %s_reach: got %0d want %0d", name, Q, target); end
  endtask

  task automatic test_mid_reset;
    advance_to(4'd7, "mid");
    #2 reset = 1'b0;
    #1;
    total++;
    if (Q !== 4'd0) begin bad++; $display("FAIL mid_async_clear: got %0d want 0", Q); end
    #10;
    total++;
    if (Q !== 4'd0) begin bad++; $display("FAIL mid_hold: got %0d want 0", Q); end
    reset = 1'b1;
    tick();
    total++;
    if (Q !== 4'd1) begin bad++; $display("FAIL mid_restart: got %0d want 1", Q); end
    exp_q = 4'd1;
  endtask

  task automatic test_coincident_reset;
    advance_to(4'd12, "coinc");
    @(posedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (Q !== 4'd0) begin bad++; $display("FAIL coinc_clear: got %0d want 0", Q); end
    tick();
    total++;
    if (Q !== 4'd0) begin bad++; $display("FAIL coinc_hold: got %0d want 0", Q); end
    reset = 1'b1;
    tick();
    total++;
    if (Q !== 4'd1) begin bad++; $display("FAIL coinc_resume: got %0d want 1", Q); end
    tick();
    total++;
    if (Q !== 4'd2) begin bad++; $display("FAIL coinc_resume2: got %0d want 2", Q); end
    exp_q = 4'd2;
  endtask

  task automatic test_illegal;
    logic [3:0] want [4];
    want = '{4'd0, 4'd1, 4'd2, 4'd3};
    force dut.u_cnt.count_q = 4'd14;
    #1 release dut.u_cnt.count_q;
    #1;
    total++;
    if (Q !== 4'd14) begin bad++; $display("FAIL illegal_setup: got %0d want 14", Q); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (Q !== want[i]) begin bad++; $display("FAIL illegal_recover[%0d]: got %0d want %0d", i, Q, want[i]); end
    end
  endtask

  initial begin
    exp_q = 4'd0;
    test_reset();
    test_count_13();
    test_run_30();
    test_mid_reset();
    test_coincident_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
